// File: rtl/trdb_pkg.sv
// Shared definitions for the trace packet decoder: format encodings and the
// bit offsets of the packet header.
package trdb_pkg;

  typedef enum logic [1:0] {
    F_BRANCH_FULL = 2'b00,
    F_BRANCH_DIFF = 2'b01,
    F_ADDR_ONLY   = 2'b10,
    F_SYNC        = 2'b11
  } trdb_format_t;

  typedef enum logic [1:0] {
    SF_START     = 2'b00,
    SF_EXCEPTION = 2'b01,
    SF_CONTEXT   = 2'b10,
    SF_RESERVED  = 2'b11
  } trdb_subformat_t;

  localparam int PACKET_LEN    = 128;
  localparam int WORD_LEN      = 32;
  localparam int HEADER_LEN    = 7;   // width of the packet length field
  localparam int FORMAT_OFF    = 7;
  localparam int FORMAT_LEN    = 2;
  localparam int PAYLOAD_OFF   = 9;
  localparam int BRANCHES_LEN  = 5;
  localparam int MAP_LEN       = 31;
  localparam int SUBFORMAT_LEN = 2;

endpackage

// File: rtl/trdb_packet_unpack.sv
// Combinational field extraction from an assembled trace packet buffer.
// Flags unsupported formats and layouts that do not fit in the packet length.
module trdb_packet_unpack
  import trdb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PRIVLEN  = 3,
  parameter int CAUSELEN = 5
) (
  input  logic [PACKET_LEN-1:0]   buf_i,
  input  logic [HEADER_LEN:0]     len_i,
  output trdb_format_t            format_o,
  output trdb_subformat_t         subformat_o,
  output logic [PRIVLEN-1:0]      priv_o,
  output logic                    branch_o,
  output logic [BRANCHES_LEN-1:0] branches_o,
  output logic [MAP_LEN-1:0]      branch_map_o,
  output logic [XLEN-1:0]         address_o,
  output logic [CAUSELEN-1:0]     cause_o,
  output logic                    interrupt_o,
  output logic                    malformed_o
);

  localparam int MAP_OFF   = PAYLOAD_OFF + BRANCHES_LEN;
  localparam int PRIV_OFF  = PAYLOAD_OFF + SUBFORMAT_LEN;
  localparam int SBR_OFF   = PRIV_OFF + PRIVLEN;
  localparam int SADDR_OFF = SBR_OFF + 1;
  localparam int CAUSE_OFF = SADDR_OFF + XLEN;

  trdb_format_t            fmt;
  trdb_subformat_t         sub;
  logic [BRANCHES_LEN-1:0] nb;
  logic [BRANCHES_LEN:0]   map_len;
  int                      need;
  logic                    unsupported;

  always_comb begin
    fmt          = trdb_format_t'(buf_i[FORMAT_OFF +: FORMAT_LEN]);
    sub          = SF_START;
    nb           = '0;
    map_len      = '0;
    need         = PAYLOAD_OFF;
    unsupported  = 1'b0;
    priv_o       = '0;
    branch_o     = 1'b0;
    branch_map_o = '0;
    address_o    = '0;
    cause_o      = '0;
    interrupt_o  = 1'b0;
    case (fmt)
      F_BRANCH_FULL: begin
        nb           = buf_i[PAYLOAD_OFF +: BRANCHES_LEN];
        // A zero branch count means a completely filled map
        map_len      = (nb == '0) ? (BRANCHES_LEN+1)'(MAP_LEN) : {1'b0, nb};
        branch_map_o = buf_i[MAP_OFF +: MAP_LEN]
                       & ({MAP_LEN{1'b1}} >> ((BRANCHES_LEN+1)'(MAP_LEN) - map_len));
        address_o    = XLEN'(buf_i >> (MAP_OFF + int'(map_len)));
        need         = MAP_OFF + int'(map_len) + XLEN;
      end
      F_ADDR_ONLY: begin
        address_o = buf_i[PAYLOAD_OFF +: XLEN];
        need      = PAYLOAD_OFF + XLEN;
      end
      F_SYNC: begin
        sub       = trdb_subformat_t'(buf_i[PAYLOAD_OFF +: SUBFORMAT_LEN]);
        priv_o    = buf_i[PRIV_OFF +: PRIVLEN];
        branch_o  = buf_i[SBR_OFF];
        address_o = buf_i[SADDR_OFF +: XLEN];
        need      = CAUSE_OFF;
        if (sub == SF_EXCEPTION) begin
          cause_o     = buf_i[CAUSE_OFF +: CAUSELEN];
          interrupt_o = buf_i[CAUSE_OFF + CAUSELEN];
          need        = CAUSE_OFF + CAUSELEN + 1;
        end else if (sub != SF_START) begin
          unsupported = 1'b1;
        end
      end
      default: unsupported = 1'b1;
    endcase
    format_o    = fmt;
    subformat_o = sub;
    branches_o  = nb;
    malformed_o = unsupported || (need > int'(len_i));
  end

endmodule

// File: rtl/trdb_packet_decoder.sv
// Reassembles word-serialized trace packets and presents decoded fields with a
// valid/ready handshake. Define TRDB_DECODER_ERR_CNT_EN to build the error counter.
module trdb_packet_decoder
  import trdb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PRIVLEN  = 3,
  parameter int CAUSELEN = 5
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [WORD_LEN-1:0]     word_i,
  input  logic                    word_valid_i,
  output logic                    word_ready_o,
  output logic                    pkt_valid_o,
  input  logic                    pkt_ready_i,
  output trdb_format_t            format_o,
  output trdb_subformat_t         subformat_o,
  output logic [PRIVLEN-1:0]      priv_o,
  output logic                    branch_o,
  output logic [BRANCHES_LEN-1:0] branches_o,
  output logic [MAP_LEN-1:0]      branch_map_o,
  output logic [XLEN-1:0]         address_o,
  output logic [CAUSELEN-1:0]     cause_o,
  output logic                    interrupt_o,
  output logic                    error_o,
  output logic [15:0]             err_cnt_o
);

  typedef enum logic [1:0] {S_HEADER, S_COLLECT, S_EMIT} state_t;

  state_t                  state_q, state_d;
  logic [PACKET_LEN-1:0]   buf_q, buf_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [HEADER_LEN:0]     len;
  logic [2:0]              n_words;
  logic                    hdr_bad, last_word, load_pkt, err_d, error_q;

  trdb_format_t            u_format;
  trdb_subformat_t         u_subformat;
  logic [PRIVLEN-1:0]      u_priv;
  logic                    u_branch;
  logic [BRANCHES_LEN-1:0] u_branches;
  logic [MAP_LEN-1:0]      u_map;
  logic [XLEN-1:0]         u_address;
  logic [CAUSELEN-1:0]     u_cause;
  logic                    u_interrupt;
  logic                    u_malformed;

  assign word_ready_o = (state_q != S_EMIT);
  assign pkt_valid_o  = (state_q == S_EMIT);
  assign error_o      = error_q;

  // The header word is still on the input while it is being accepted
  assign len       = (state_q == S_HEADER) ? {1'b0, word_i[HEADER_LEN-1:0]}
                                           : {1'b0, buf_q[HEADER_LEN-1:0]};
  assign n_words   = 3'((int'(len) + WORD_LEN - 1) / WORD_LEN);
  assign hdr_bad   = (int'(len) < PAYLOAD_OFF) || (int'(len) > PACKET_LEN);
  assign last_word = (state_q == S_HEADER) ? (n_words == 3'd1)
                                           : (cnt_q == 2'(n_words - 3'd1));

  always_comb begin
    buf_d = buf_q;
    if (state_q == S_HEADER) begin
      buf_d                 = '0;
      buf_d[WORD_LEN-1:0]   = word_i;
    end else begin
      buf_d[{cnt_q, 5'b0} +: WORD_LEN] = word_i;
    end
  end

  trdb_packet_unpack #(
    .XLEN     (XLEN),
    .PRIVLEN  (PRIVLEN),
    .CAUSELEN (CAUSELEN)
  ) u_unpack (
    .buf_i        (buf_d),
    .len_i        (len),
    .format_o     (u_format),
    .subformat_o  (u_subformat),
    .priv_o       (u_priv),
    .branch_o     (u_branch),
    .branches_o   (u_branches),
    .branch_map_o (u_map),
    .address_o    (u_address),
    .cause_o      (u_cause),
    .interrupt_o  (u_interrupt),
    .malformed_o  (u_malformed)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_pkt = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_HEADER: begin
        if (word_valid_i) begin
          cnt_d = 2'd1;
          if (hdr_bad) begin
            err_d = 1'b1;
          end else if (last_word) begin
            err_d    = u_malformed;
            load_pkt = !u_malformed;
            state_d  = u_malformed ? S_HEADER : S_EMIT;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (word_valid_i) begin
          cnt_d = cnt_q + 2'd1;
          if (last_word) begin
            err_d    = u_malformed;
            load_pkt = !u_malformed;
            state_d  = u_malformed ? S_HEADER : S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (pkt_ready_i) state_d = S_HEADER;
      end
      default: state_d = S_HEADER;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_HEADER;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (word_valid_i && word_ready_o) buf_q <= buf_d;
  end

  // Output registers hold the decoded packet for the whole S_EMIT stall
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      format_o     <= F_BRANCH_FULL;
      subformat_o  <= SF_START;
      priv_o       <= '0;
      branch_o     <= 1'b0;
      branches_o   <= '0;
      branch_map_o <= '0;
      address_o    <= '0;
      cause_o      <= '0;
      interrupt_o  <= 1'b0;
    end else if (load_pkt) begin
      format_o     <= u_format;
      subformat_o  <= u_subformat;
      priv_o       <= u_priv;
      branch_o     <= u_branch;
      branches_o   <= u_branches;
      branch_map_o <= u_map;
      address_o    <= u_address;
      cause_o      <= u_cause;
      interrupt_o  <= u_interrupt;
    end
  end

`ifdef TRDB_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (error_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = '0;
`endif

endmodule

// File: tb/tb_trdb_packet_decoder.sv
// Scoreboard bench for trdb_packet_decoder: packets are packed from field
// values, expected decodes are queued and compared when the packet is presented.
module tb_trdb_packet_decoder;
  import trdb_pkg::*;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [31:0]     word_i = '0;
  logic            word_valid_i = 1'b0;
  logic            word_ready_o;
  logic            pkt_valid_o;
  logic            pkt_ready_i = 1'b0;
  trdb_format_t    format_o;
  trdb_subformat_t subformat_o;
  logic [2:0]      priv_o;
  logic            branch_o;
  logic [4:0]      branches_o;
  logic [30:0]     branch_map_o;
  logic [31:0]     address_o;
  logic [4:0]      cause_o;
  logic            interrupt_o;
  logic            error_o;
  logic [15:0]     err_cnt_o;

  int total = 0;
  int passed = 0;
  int err_seen = 0;

  typedef struct packed {
    logic [1:0]  fmt;
    logic [1:0]  sub;
    logic [2:0]  priv;
    logic        br;
    logic [4:0]  branches;
    logic [30:0] map;
    logic [31:0] addr;
    logic [4:0]  cause;
    logic        intr;
  } exp_t;

  exp_t exp_q[$];

`ifdef TRDB_DECODER_ERR_CNT_EN
  localparam logic [15:0] EXP_ERR_CNT = 16'd2;
`else
  localparam logic [15:0] EXP_ERR_CNT = 16'd0;
`endif

  trdb_packet_decoder dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .word_i       (word_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_ready_i  (pkt_ready_i),
    .format_o     (format_o),
    .subformat_o  (subformat_o),
    .priv_o       (priv_o),
    .branch_o     (branch_o),
    .branches_o   (branches_o),
    .branch_map_o (branch_map_o),
    .address_o    (address_o),
    .cause_o      (cause_o),
    .interrupt_o  (interrupt_o),
    .error_o      (error_o),
    .err_cnt_o    (err_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (error_o === 1'b1) err_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d passed=%0d", total, passed);
    $fatal(1);
  end

  function automatic exp_t obs();
    return {format_o, subformat_o, priv_o, branch_o, branches_o, branch_map_o,
            address_o, cause_o, interrupt_o};
  endfunction

  function automatic logic [127:0] put(logic [127:0] p, int off, logic [31:0] v, int w);
    for (int i = 0; i < w; i++) p[off+i] = v[i];
    return p;
  endfunction

  // Random filler after the last packet bit, inside the last word
  function automatic logic [127:0] junk_tail(logic [127:0] p, int len);
    for (int i = len; i < ((len + 31) / 32) * 32; i++) p[i] = 1'($urandom);
    return p;
  endfunction

  function automatic logic [127:0] mk_addr(logic [31:0] a, output int len);
    logic [127:0] p;
    len = 41;
    p = put('0, 0, 32'(len), 7);
    p = put(p, 7, 32'd2, 2);
    p = put(p, 9, a, 32);
    return junk_tail(p, len);
  endfunction

  function automatic logic [127:0] mk_bfull(logic [4:0] nb, logic [30:0] map,
                                            logic [31:0] a, output int len);
    logic [127:0] p;
    int mlen;
    mlen = (nb == 0) ? 31 : int'(nb);
    len = 14 + mlen + 32;
    p = put('0, 0, 32'(len), 7);
    p = put(p, 7, 32'd0, 2);
    p = put(p, 9, 32'(nb), 5);
    p = put(p, 14, {1'b0, map}, mlen);
    p = put(p, 14 + mlen, a, 32);
    return junk_tail(p, len);
  endfunction

  function automatic logic [127:0] mk_sync(logic [1:0] sf, logic [2:0] pr, logic br,
                                           logic [31:0] a, logic [4:0] c, logic intr,
                                           output int len);
    logic [127:0] p;
    len = (sf == 2'b01) ? 53 : 47;
    p = put('0, 0, 32'(len), 7);
    p = put(p, 7, 32'd3, 2);
    p = put(p, 9, 32'(sf), 2);
    p = put(p, 11, 32'(pr), 3);
    p = put(p, 14, 32'(br), 1);
    p = put(p, 15, a, 32);
    if (sf == 2'b01) begin
      p = put(p, 47, 32'(c), 5);
      p = put(p, 52, 32'(intr), 1);
    end
    return junk_tail(p, len);
  endfunction

  task automatic send_word(input logic [31:0] w);
    int t = 0;
    word_i = w;
    word_valid_i = 1'b1;
    while (word_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      total++;
      $display("FAIL word_ready_timeout got=%b want=1", word_ready_o);
    end
    @(posedge clk);
    #1;
    word_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [127:0] p, input int len);
    for (int i = 0; i < (len + 31) / 32; i++) send_word(p[32*i +: 32]);
  endtask

  task automatic wait_valid(output bit ok);
    int t = 0;
    while (pkt_valid_o !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (pkt_valid_o === 1'b1);
  endtask

  task automatic consume();
    pkt_ready_i = 1'b1;
    @(posedge clk);
    #1;
    pkt_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (word_ready_o !== 1'b1) $display("FAIL reset_word_ready got=%b want=1", word_ready_o); else passed++;
    total++; if (pkt_valid_o !== 1'b0) $display("FAIL reset_pkt_valid got=%b want=0", pkt_valid_o); else passed++;
    total++; if (error_o !== 1'b0) $display("FAIL reset_error got=%b want=0", error_o); else passed++;
    total++; if (err_cnt_o !== 16'd0) $display("FAIL reset_err_cnt got=%0d want=0", err_cnt_o); else passed++;
    total++; if (obs() !== exp_t'(0)) $display("FAIL reset_fields got=%h want=0", obs()); else passed++;
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addr_only();
    logic [127:0] p;
    int len;
    exp_t e;
    p = mk_addr(32'h1C00_0080, len);
    e = '0; e.fmt = 2'b10; e.addr = 32'h1C00_0080;
    exp_q.push_back(e);
    send_word(p[31:0]);
    total++; if (pkt_valid_o !== 1'b0) $display("FAIL addr_early_valid got=%b want=0", pkt_valid_o); else passed++;
    send_word(p[63:32]);
    total++; if (pkt_valid_o !== 1'b1) $display("FAIL addr_latency got=%b want=1", pkt_valid_o); else passed++;
    e = exp_q.pop_front();
    total++; if (format_o !== F_ADDR_ONLY) $display("FAIL addr_format got=%b want=10", format_o); else passed++;
    total++; if (obs() !== e) $display("FAIL addr_fields got=%h want=%h", obs(), e); else passed++;
    consume();
    total++; if (pkt_valid_o !== 1'b0 || word_ready_o !== 1'b1)
      $display("FAIL addr_release got=%b%b want=01", pkt_valid_o, word_ready_o); else passed++;
  endtask

  task automatic test_bfull_partial();
    logic [127:0] p;
    int len;
    bit ok;
    exp_t e;
    p = mk_bfull(5'd3, 31'b101, 32'h1C00_0100, len);
    e = '0; e.branches = 5'd3; e.map = 31'h5; e.addr = 32'h1C00_0100;
    exp_q.push_back(e);
    send_pkt(p, len);
    wait_valid(ok);
    total++; if (!ok) $display("FAIL bpart_valid_timeout got=0 want=1"); else passed++;
    e = exp_q.pop_front();
    total++; if (branches_o !== 5'd3 || branch_map_o !== 31'h5)
      $display("FAIL bpart_map got=%0d/%h want=3/5", branches_o, branch_map_o); else passed++;
    total++; if (obs() !== e) $display("FAIL bpart_fields got=%h want=%h", obs(), e); else passed++;
    consume();
  endtask

  task automatic test_bfull_full();
    logic [127:0] p;
    int len;
    bit ok;
    exp_t e, snap;
    p = mk_bfull(5'd0, 31'h7FFF_FFFF, 32'h1C00_0180, len);
    e = '0; e.map = 31'h7FFF_FFFF; e.addr = 32'h1C00_0180;
    exp_q.push_back(e);
    send_pkt(p, len);
    wait_valid(ok);
    total++; if (!ok) $display("FAIL bfull_valid_timeout got=0 want=1"); else passed++;
    e = exp_q.pop_front();
    total++; if (obs() !== e) $display("FAIL bfull_fields got=%h want=%h", obs(), e); else passed++;
    snap = e;
    word_i = 32'hDEAD_BEEF;
    word_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (obs() !== snap || pkt_valid_o !== 1'b1)
        $display("FAIL bfull_hold_%0d got=%h want=%h", i, obs(), snap); else passed++;
      total++; if (word_ready_o !== 1'b0)
        $display("FAIL bfull_hold_ready_%0d got=%b want=0", i, word_ready_o); else passed++;
    end
    word_valid_i = 1'b0;
    consume();
  endtask

  task automatic test_sync_exc();
    logic [127:0] p;
    int len;
    bit ok;
    exp_t e;
    p = mk_sync(2'b01, 3'd3, 1'b1, 32'h1C00_0200, 5'd11, 1'b0, len);
    e = '0; e.fmt = 2'b11; e.sub = 2'b01; e.priv = 3'd3; e.br = 1'b1;
    e.addr = 32'h1C00_0200; e.cause = 5'd11;
    exp_q.push_back(e);
    send_pkt(p, len);
    wait_valid(ok);
    total++; if (!ok) $display("FAIL sync_valid_timeout got=0 want=1"); else passed++;
    e = exp_q.pop_front();
    total++; if (obs() !== e) $display("FAIL sync_fields got=%h want=%h", obs(), e); else passed++;
    consume();
  endtask

  task automatic test_back_to_back();
    pkt_ready_i = 1'b1;
    fork
      begin
        logic [127:0] p;
        int len, nb;
        logic [30:0] m;
        logic [31:0] a;
        exp_t e;
        a = $urandom;
        p = mk_addr(a, len);
        e = '0; e.fmt = 2'b10; e.addr = a;
        exp_q.push_back(e);
        send_pkt(p, len);
        a = $urandom;
        e = '0; e.fmt = 2'b11; e.priv = 3'($urandom); e.br = 1'($urandom); e.addr = a;
        p = mk_sync(2'b00, e.priv, e.br, a, 5'd0, 1'b0, len);
        exp_q.push_back(e);
        send_pkt(p, len);
        a = $urandom;
        nb = $urandom_range(1, 31);
        m = 31'($urandom);
        e = '0; e.branches = 5'(nb); e.addr = a;
        for (int i = 0; i < nb; i++) e.map[i] = m[i];
        p = mk_bfull(5'(nb), m, a, len);
        exp_q.push_back(e);
        send_pkt(p, len);
      end
      begin
        bit ok;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
          wait_valid(ok);
          total++; if (!ok) $display("FAIL b2b_valid_timeout_%0d got=0 want=1", k); else passed++;
          if (ok) begin
            e = exp_q.pop_front();
            total++; if (obs() !== e) $display("FAIL b2b_fields_%0d got=%h want=%h", k, obs(), e); else passed++;
          end
          @(posedge clk);
          #1;
        end
      end
    join
    pkt_ready_i = 1'b0;
  endtask

  task automatic test_error();
    logic [127:0] p;
    logic [31:0] w;
    int len, e0;
    bit ok;
    exp_t e;
    e0 = err_seen;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[6:0] = 7'd40;
    p[8:7] = 2'b01;
    send_word(p[31:0]);
    total++; if (error_o !== 1'b0) $display("FAIL err_early got=%b want=0", error_o); else passed++;
    send_word(p[63:32]);
    total++; if (error_o !== 1'b1 || pkt_valid_o !== 1'b0)
      $display("FAIL err_diff got=%b%b want=10", error_o, pkt_valid_o); else passed++;
    w = $urandom;
    w[6:0] = 7'd5;
    send_word(w);
    total++; if (error_o !== 1'b1 || pkt_valid_o !== 1'b0)
      $display("FAIL err_short_hdr got=%b%b want=10", error_o, pkt_valid_o); else passed++;
    @(posedge clk);
    #1;
    total++; if (error_o !== 1'b0 || word_ready_o !== 1'b1)
      $display("FAIL err_pulse_end got=%b%b want=01", error_o, word_ready_o); else passed++;
    p = mk_addr(32'h1C00_0300, len);
    e = '0; e.fmt = 2'b10; e.addr = 32'h1C00_0300;
    exp_q.push_back(e);
    send_pkt(p, len);
    wait_valid(ok);
    total++; if (!ok) $display("FAIL err_recover_timeout got=0 want=1"); else passed++;
    e = exp_q.pop_front();
    total++; if (obs() !== e) $display("FAIL err_recover_fields got=%h want=%h", obs(), e); else passed++;
    consume();
    repeat (2) @(posedge clk);
    #1;
    total++; if (err_seen - e0 !== 2) $display("FAIL err_pulses got=%0d want=2", err_seen - e0); else passed++;
    total++; if (err_cnt_o !== EXP_ERR_CNT) $display("FAIL err_cnt got=%0d want=%0d", err_cnt_o, EXP_ERR_CNT); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [127:0] p;
    int len;
    bit ok;
    exp_t e;
    p = mk_bfull(5'd0, 31'h1234_5678, 32'h1C00_0400, len);
    send_word(p[31:0]);
    send_word(p[63:32]);
    rst_ni = 1'b0;
    #1;
    total++; if (word_ready_o !== 1'b1 || pkt_valid_o !== 1'b0 || error_o !== 1'b0)
      $display("FAIL rstmid_ctrl got=%b%b%b want=100", word_ready_o, pkt_valid_o, error_o); else passed++;
    total++; if (obs() !== exp_t'(0) || err_cnt_o !== 16'd0)
      $display("FAIL rstmid_fields got=%h/%0d want=0/0", obs(), err_cnt_o); else passed++;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk);
    p = mk_addr(32'h1C00_0500, len);
    e = '0; e.fmt = 2'b10; e.addr = 32'h1C00_0500;
    exp_q.push_back(e);
    send_pkt(p, len);
    wait_valid(ok);
    total++; if (!ok) $display("FAIL rstmid_valid_timeout got=0 want=1"); else passed++;
    e = exp_q.pop_front();
    total++; if (obs() !== e) $display("FAIL rstmid_fields_after got=%h want=%h", obs(), e); else passed++;
    total++; if (error_o !== 1'b0) $display("FAIL rstmid_error got=%b want=0", error_o); else passed++;
    consume();
  endtask

  initial begin
    test_reset();
    test_addr_only();
    test_bfull_partial();
    test_bfull_full();
    test_sync_exc();
    test_back_to_back();
    test_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
